// File: rtl/multi_channel_transfer_unit_pkg.sv
// Shared types and channel indices for the DRAM<->GLB transfer engine.
package transfer_pkg;

  typedef enum logic [1:0] {IDLE, FWD, BWD, DONE} state_t;
  typedef enum logic {DIR_FWD = 1'b0, DIR_BWD = 1'b1} dir_t;

  localparam int CH_IFMAP  = 0;
  localparam int CH_FILTER = 1;
  localparam int CH_BIAS   = 2;
  localparam int CH_PSUM   = 3;

endpackage

// File: rtl/multi_channel_transfer_unit_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra bit to tell full from empty.
module sync_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [DATA_WIDTH-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr_q, rd_ptr_q;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_i) mem[wr_ptr_q[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/multi_channel_transfer_unit.sv
// Credit-controlled block mover between DRAM and one of NUM_CH GLB channels.
module multi_channel_transfer_unit
  import transfer_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 20,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic                  core_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  dir,
  input  logic [CH_W-1:0]       channel_sel,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] words_num,
  output logic                  busy,
  output logic                  transfer_done,
  output logic                  cfg_error,
  output logic                  r_en_DRAM,
  input  logic                  valid_from_DRAM,
  input  logic [DATA_WIDTH-1:0] wdata_from_DRAM,
  output logic                  w_en_DRAM,
  input  logic                  ready_from_DRAM,
  output logic [DATA_WIDTH-1:0] rdata_to_DRAM,
  output logic [NUM_CH-1:0]     w_en_GLB,
  output logic [DATA_WIDTH-1:0] wdata_to_GLB,
  output logic [ADDR_WIDTH-1:0] waddr_to_GLB,
  output logic [NUM_CH-1:0]     r_en_GLB,
  output logic [ADDR_WIDTH-1:0] raddr_from_GLB,
  input  logic [DATA_WIDTH-1:0] rdata_from_GLB
);
  state_t                state_q;
  logic [CH_W-1:0]       ch_q;
  logic [ADDR_WIDTH-1:0] base_q, words_q, issued_q, retired_q, retired_d;
  logic                  busy_q, done_q, cfg_err_q, r_en_dram_q, w_en_dram_q, rd_pend_q;
  logic [NUM_CH-1:0]     w_en_glb_q, r_en_glb_q, ch_oh, sel_oh;
  logic [ADDR_WIDTH-1:0] waddr_q, raddr_q;
  logic [DATA_WIDTH-1:0] out_data_q, in_data, load_data, fifo_head;
  logic                  fwd, bwd, out_stall, accept, in_valid, load, credit, last;
  logic                  fifo_push, fifo_pop, fifo_empty, fifo_full;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dec
    assign ch_oh[gi]  = (ch_q == CH_W'(gi));
    assign sel_oh[gi] = (channel_sel == CH_W'(gi));
  end

  // A single output stage holds the word being delivered; when the FIFO is
  // empty an arriving word bypasses straight into it to keep 1-cycle latency.
  assign fwd       = (state_q == FWD);
  assign bwd       = (state_q == BWD);
  assign out_stall = w_en_dram_q && !ready_from_DRAM;
  assign accept    = w_en_dram_q && ready_from_DRAM;
  assign in_valid  = (fwd && valid_from_DRAM) || (bwd && rd_pend_q);
  assign in_data   = fwd ? wdata_from_DRAM : rdata_from_GLB;
  assign load      = (fwd || bwd) && !out_stall && (!fifo_empty || in_valid);
  assign fifo_pop  = load && !fifo_empty;
  assign fifo_push = in_valid && (out_stall || !fifo_empty) && (!fifo_full || fifo_pop);
  assign load_data = fifo_empty ? in_data : fifo_head;
  assign retired_d = retired_q + ADDR_WIDTH'(fwd ? load : (bwd && accept));
  assign credit    = (issued_q < words_q) && ((issued_q - retired_q) < ADDR_WIDTH'(DEPTH));
  assign last      = fwd ? (retired_q == words_q) : (retired_d == words_q);

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(core_clk), .rst(reset), .push_i(fifo_push), .data_i(in_data), .pop_i(fifo_pop),
    .empty_o(fifo_empty), .full_o(fifo_full), .head_o(fifo_head)
  );

  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;      ch_q <= '0;        base_q <= '0;     words_q <= '0;
      issued_q <= '0;       retired_q <= '0;   busy_q <= 1'b0;   done_q <= 1'b0;
      cfg_err_q <= 1'b0;    r_en_dram_q <= 1'b0; w_en_dram_q <= 1'b0; rd_pend_q <= 1'b0;
      w_en_glb_q <= '0;     r_en_glb_q <= '0;  waddr_q <= '0;    raddr_q <= '0;
      out_data_q <= '0;
    end else begin
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      r_en_dram_q <= 1'b0;
      r_en_glb_q  <= '0;
      rd_pend_q   <= |r_en_glb_q;
      case (state_q)
        IDLE: if (start) begin
          if (32'(channel_sel) >= 32'(NUM_CH)) begin
            cfg_err_q <= 1'b1;
          end else if (words_num == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            ch_q      <= channel_sel;
            base_q    <= base_addr;
            words_q   <= words_num;
            issued_q  <= ADDR_WIDTH'(1);
            retired_q <= '0;
            busy_q    <= 1'b1;
            if (dir_t'(dir) == DIR_BWD) begin
              state_q    <= BWD;
              r_en_glb_q <= sel_oh;
              raddr_q    <= base_addr;
            end else begin
              state_q     <= FWD;
              r_en_dram_q <= 1'b1;
            end
          end
        end
        FWD, BWD: begin
          if (start) cfg_err_q <= 1'b1;
          if (credit) begin
            issued_q <= issued_q + 1'b1;
            if (fwd) begin
              r_en_dram_q <= 1'b1;
            end else begin
              r_en_glb_q <= ch_oh;
              raddr_q    <= base_q + issued_q;
            end
          end
          retired_q <= retired_d;
          if (!out_stall) begin
            w_en_glb_q  <= (fwd && load) ? ch_oh : '0;
            w_en_dram_q <= bwd && load;
            if (load) begin
              out_data_q <= load_data;
              if (fwd) waddr_q <= base_q + retired_q;
            end
          end
          if (last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign transfer_done  = done_q;
  assign cfg_error      = cfg_err_q;
  assign r_en_DRAM      = r_en_dram_q;
  assign w_en_DRAM      = w_en_dram_q;
  assign rdata_to_DRAM  = out_data_q;
  assign w_en_GLB       = w_en_glb_q;
  assign wdata_to_GLB   = out_data_q;
  assign waddr_to_GLB   = waddr_q;
  assign r_en_GLB       = r_en_glb_q;
  assign raddr_from_GLB = raddr_q;

endmodule

// File: tb/tb_multi_channel_transfer_unit.sv
// Directed bench: DRAM/GLB behavioural models feeding per-word checks plus per-transfer totals.
module tb_multi_channel_transfer_unit;
  import transfer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, dir, valid_from_DRAM, ready_from_DRAM;
  logic [2:0]  channel_sel;
  logic [19:0] base_addr, words_num, waddr_to_GLB, raddr_from_GLB;
  logic [63:0] wdata_from_DRAM, rdata_to_DRAM, wdata_to_GLB, rdata_from_GLB;
  logic        busy, transfer_done, cfg_error, r_en_DRAM, w_en_DRAM;
  logic [3:0]  w_en_GLB, r_en_GLB;

  multi_channel_transfer_unit #(
    .DATA_WIDTH(64), .NUM_CH(4), .DEPTH(16), .ADDR_WIDTH(20), .CH_W(3)
  ) dut (
    .core_clk(clk), .reset(reset), .start(start), .dir(dir), .channel_sel(channel_sel),
    .base_addr(base_addr), .words_num(words_num), .busy(busy), .transfer_done(transfer_done),
    .cfg_error(cfg_error), .r_en_DRAM(r_en_DRAM), .valid_from_DRAM(valid_from_DRAM),
    .wdata_from_DRAM(wdata_from_DRAM), .w_en_DRAM(w_en_DRAM), .ready_from_DRAM(ready_from_DRAM),
    .rdata_to_DRAM(rdata_to_DRAM), .w_en_GLB(w_en_GLB), .wdata_to_GLB(wdata_to_GLB),
    .waddr_to_GLB(waddr_to_GLB), .r_en_GLB(r_en_GLB), .raddr_from_GLB(raddr_from_GLB),
    .rdata_from_GLB(rdata_from_GLB)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0, cyc = 0;
  int req_cnt, wr_cnt, rd_cnt, acc_cnt, done_cnt, cfg_cnt, en_cnt, max_out, done_cyc, hold_cnt;
  int cur_ch, cur_lat, start_cyc;
  bit cur_dir, cur_toggle, busy_at_done, held, prev_rd;
  logic [19:0] cur_base, prev_addr;
  logic [63:0] held_data;
  int          ret_t[$];
  logic [63:0] ret_d[$];

  function automatic logic [63:0] fwd_data(input int n);
    return 64'hF00D_0000_0000_0000 | 64'(n);
  endfunction

  function automatic logic [63:0] glb_data(input logic [19:0] a);
    return 64'hB0B0_0000_0000_0000 | 64'(a);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 64'({busy, transfer_done, cfg_error, r_en_DRAM, w_en_DRAM, w_en_GLB, r_en_GLB}), 64'h0);
    check({tag, "_addr"}, 64'({waddr_to_GLB, raddr_from_GLB}), 64'h0);
    check({tag, "_data"}, wdata_to_GLB | rdata_to_DRAM, 64'h0);
  endtask

  // One clock: observe this cycle's registered outputs, then drive this cycle's inputs.
  task automatic tick();
    logic [19:0] a;
    @(posedge clk);
    #1;
    cyc++;
    if (transfer_done) begin done_cnt++; done_cyc = cyc; busy_at_done = busy; end
    if (cfg_error) cfg_cnt++;
    if (r_en_DRAM || (|r_en_GLB) || (|w_en_GLB) || w_en_DRAM) en_cnt++;
    if (r_en_DRAM) begin
      ret_t.push_back(cyc + cur_lat);
      ret_d.push_back(fwd_data(req_cnt));
      req_cnt++;
    end
    if (|w_en_GLB) begin
      a = cur_base + 20'(wr_cnt);
      check("glb_wen", 64'(w_en_GLB), 64'(4'b0001 << cur_ch));
      check("glb_waddr", 64'(waddr_to_GLB), 64'(a));
      check("glb_wdata", wdata_to_GLB, fwd_data(wr_cnt));
      wr_cnt++;
    end
    if (req_cnt - wr_cnt > max_out) max_out = req_cnt - wr_cnt;
    rdata_from_GLB = prev_rd ? glb_data(prev_addr) : 64'h0;
    prev_rd = |r_en_GLB;
    if (prev_rd) begin
      a = cur_base + 20'(rd_cnt);
      check("glb_ren", 64'(r_en_GLB), 64'(4'b0001 << cur_ch));
      check("glb_raddr", 64'(raddr_from_GLB), 64'(a));
      prev_addr = raddr_from_GLB;
      rd_cnt++;
    end
    if (held) begin
      check("dram_hold_en", 64'(w_en_DRAM), 64'h1);
      check("dram_hold_data", rdata_to_DRAM, held_data);
    end
    ready_from_DRAM = cur_toggle ? ((cyc % 2) == 0) : 1'b1;
    if (w_en_DRAM && ready_from_DRAM) begin
      a = cur_base + 20'(acc_cnt);
      check("dram_wdata", rdata_to_DRAM, glb_data(a));
      acc_cnt++;
    end
    held = w_en_DRAM && !ready_from_DRAM;
    if (held) hold_cnt++;
    held_data = rdata_to_DRAM;
    if (ret_t.size() > 0 && ret_t[0] == cyc) begin
      valid_from_DRAM = 1'b1;
      wdata_from_DRAM = ret_d[0];
      void'(ret_t.pop_front());
      void'(ret_d.pop_front());
    end else if (cur_dir) begin
      valid_from_DRAM = 1'b1;
      wdata_from_DRAM = 64'hDEAD_DEAD_DEAD_DEAD;
    end else begin
      valid_from_DRAM = 1'b0;
      wdata_from_DRAM = 64'h0;
    end
  endtask

  task automatic prep(input bit d, input int ch, input logic [19:0] base, input int n,
                      input int lat, input bit tog);
    req_cnt = 0; wr_cnt = 0; rd_cnt = 0; acc_cnt = 0; done_cnt = 0; cfg_cnt = 0;
    en_cnt = 0; max_out = 0; hold_cnt = 0; held = 0; prev_rd = 0;
    ret_t.delete(); ret_d.delete();
    cur_dir = d; cur_ch = ch; cur_base = base; cur_lat = lat; cur_toggle = tog;
    dir = d; channel_sel = 3'(ch); base_addr = base; words_num = 20'(n);
    start = 1'b1; start_cyc = cyc;
  endtask

  task automatic run_xfer(input string tag, input bit d, input int ch, input logic [19:0] base,
                          input int n, input int lat, input bit tog, input int dup_at,
                          input int exp_lat);
    int k;
    prep(d, ch, base, n, lat, tog);
    tick();
    start = 1'b0;
    if (n > 0) check({tag, "_start_lat"}, 64'(d ? rd_cnt : req_cnt), 64'd1);
    k = 0;
    while (done_cnt == 0 && k < 600) begin
      if (k == dup_at) begin
        dir = ~d; channel_sel = 3'(CH_IFMAP); words_num = 20'd3; start = 1'b1;
      end
      tick();
      start = 1'b0;
      if (k == dup_at) check({tag, "_busy_cfg_err"}, 64'(cfg_error), 64'h1);
      k++;
    end
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    if (exp_lat >= 0) check({tag, "_done_lat"}, 64'(done_cyc - start_cyc), 64'(exp_lat));
    check({tag, "_busy_in_done"}, 64'(busy_at_done), 64'h1);
    check({tag, "_delivered"}, 64'(d ? acc_cnt : wr_cnt), 64'(n));
    check({tag, "_requested"}, 64'(d ? rd_cnt : req_cnt), 64'(n));
    check({tag, "_cfg_cnt"}, 64'(cfg_cnt), 64'(dup_at >= 0));
    if (n == 0) check({tag, "_no_enables"}, 64'(en_cnt), 64'h0);
    tick();
    check({tag, "_busy_after"}, 64'(busy), 64'h0);
    check({tag, "_single_done"}, 64'(done_cnt), 64'd1);
    $display("xfer %s dir=%0d ch=%0d base=%05h words=%0d cycles=%0d max_out=%0d holds=%0d",
             tag, d, ch, base, n, done_cyc - start_cyc, max_out, hold_cnt);
  endtask

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; dir = 1'b0; channel_sel = '0; base_addr = '0; words_num = '0;
    valid_from_DRAM = 1'b0; wdata_from_DRAM = '0; ready_from_DRAM = 1'b1; rdata_from_GLB = '0;
    cur_dir = 0; cur_toggle = 0; cur_lat = 1; cur_ch = 0; cur_base = '0; held = 0; prev_rd = 0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    tick();

    run_xfer("fwd_lat3", 1'b0, CH_FILTER, 20'h00100, 20, 3, 1'b0, -1, 25);
    run_xfer("fwd_lat25", 1'b0, CH_IFMAP, 20'h00800, 40, 25, 1'b0, -1, -1);
    check("fwd_lat25_max_outstanding", 64'(max_out), 64'd16);
    run_xfer("bwd_bp", 1'b1, CH_PSUM, 20'hFFFFE, 5, 1, 1'b1, -1, -1);
    check("bwd_bp_held", 64'(hold_cnt > 0), 64'h1);
    run_xfer("zero_len", 1'b0, CH_BIAS, 20'h00010, 0, 1, 1'b0, -1, 1);

    prep(1'b0, 5, 20'h00000, 4, 1, 1'b0);
    tick();
    start = 1'b0;
    check("bad_ch_cfg_err", 64'(cfg_error), 64'h1);
    check("bad_ch_busy", 64'(busy), 64'h0);
    tick();
    check("bad_ch_pulse", 64'({cfg_error, busy}), 64'h0);
    check("bad_ch_no_en", 64'(en_cnt), 64'h0);
    $display("xfer bad_ch ch=5 cfg_err_pulses=%0d", cfg_cnt);

    run_xfer("busy_start", 1'b0, CH_FILTER, 20'h00100, 20, 3, 1'b0, 5, 25);

    prep(1'b0, CH_BIAS, 20'h00200, 20, 3, 1'b0);
    tick();
    start = 1'b0;
    k = 0;
    while (wr_cnt < 7 && k < 100) begin tick(); k++; end
    check("rst_mid_progress", 64'(wr_cnt), 64'd7);
    reset = 1'b1;
    #1;
    check_zero("rst_mid");
    repeat (2) tick();
    reset = 1'b0;
    repeat (8) tick();
    check("rst_mid_no_done", 64'(done_cnt), 64'h0);
    check("rst_mid_no_writes", 64'(wr_cnt), 64'd7);
    check("rst_mid_idle", 64'(busy), 64'h0);
    $display("xfer rst_mid aborted after %0d words", wr_cnt);
    run_xfer("after_rst", 1'b0, CH_BIAS, 20'h00040, 3, 3, 1'b0, -1, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
